// File: rtl/demux_1x4_fifo_pkg.sv
// ============================================================================
// demux_1x4_fifo_pkg : shared defaults and lane-select helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux_1x4_fifo_pkg;

  localparam int DATA_SIZE_DEF   = 12;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int ALMOST_FULL_DEF = 3;
  localparam int NUM_LANES       = 4;
  // Lane select occupies the LANE_SEL_W most significant bits of the data word.
  localparam int LANE_SEL_W      = 2;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_SEL_W-1:0] sel);
    logic [NUM_LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1x4_fifo_if.sv
// ============================================================================
// demux_1x4_fifo_if : upstream word stream, per-lane pops and lane status
// Revision: 1.0
// ============================================================================
`default_nettype none

interface demux_1x4_fifo_if
  import demux_1x4_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
);

  logic                 valid_in;
  logic [DATA_SIZE-1:0] data_in;
  logic                 pop0, pop1, pop2, pop3;
  logic [DATA_SIZE-1:0] data_out0, data_out1, data_out2, data_out3;
  logic                 valid_out0, valid_out1, valid_out2, valid_out3;
  logic                 empty0, empty1, empty2, empty3;
  logic                 full0, full1, full2, full3;
  logic                 pause;
  logic                 error;

  modport master (
    output valid_in, data_in, pop0, pop1, pop2, pop3,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  empty0, empty1, empty2, empty3,
    input  full0, full1, full2, full3,
    input  pause, error
  );

  modport slave (
    input  valid_in, data_in, pop0, pop1, pop2, pop3,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output empty0, empty1, empty2, empty3,
    output full0, full1, full2, full3,
    output pause, error
  );

endinterface

`default_nettype wire

// File: rtl/demux_1x4_fifo_lane.sv
// ============================================================================
// fifo_lane : single-clock FIFO with registered, latency-1 read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_lane
  import demux_1x4_fifo_pkg::*;
#(
  parameter  int DATA_SIZE  = DATA_SIZE_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = PW + 1
) (
  input  wire logic                 clk,
  input  wire logic                 reset_L,
  input  wire logic                 push_i,
  input  wire logic                 pop_i,
  input  wire logic [DATA_SIZE-1:0] data_i,
  output logic      [DATA_SIZE-1:0] data_o,
  output logic                      valid_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic      [CW-1:0]        count_o
);

  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q,  count_d;
  logic [DATA_SIZE-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 w_do_push, w_do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_DEPTH);
  assign count_o = count_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  // Status comes from registered occupancy only, so a pop never sees a same-cycle push.
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = w_do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = w_do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = w_do_pop;
    data_d  = w_do_pop ? mem_q[rd_ptr_q] : data_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_1x4_fifo.sv
// ============================================================================
// demux_1x4_fifo : routes each word to one of four FIFO lanes by its top bits
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_1x4_fifo
  import demux_1x4_fifo_pkg::*;
#(
  parameter  int DATA_SIZE   = DATA_SIZE_DEF,
  parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter  int ALMOST_FULL = ALMOST_FULL_DEF,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic         clk,
  input  wire logic         reset_L,
  demux_1x4_fifo_if.slave   bus
);

  localparam logic [CW-1:0] C_ALMOST_FULL = CW'(ALMOST_FULL);

  logic [LANE_SEL_W-1:0] w_dest;
  logic [NUM_LANES-1:0]  w_pop, w_push, w_full, w_empty, w_valid;
  logic [DATA_SIZE-1:0]  w_dout  [NUM_LANES];
  logic [CW-1:0]         w_count [NUM_LANES];
  logic                  w_drop;
  logic                  w_pause;
  logic                  error_q, error_d;

  assign w_dest = bus.data_in[DATA_SIZE-1 -: LANE_SEL_W];
  assign w_pop  = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
  assign w_push = bus.valid_in ? (lane_onehot(w_dest) & ~w_full) : '0;
  // A full destination drops the word even when that lane pops in the same cycle.
  assign w_drop = bus.valid_in && w_full[w_dest];

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      fifo_lane #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_lane (
        .clk     (clk),
        .reset_L (reset_L),
        .push_i  (w_push[gi]),
        .pop_i   (w_pop[gi]),
        .data_i  (bus.data_in),
        .data_o  (w_dout[gi]),
        .valid_o (w_valid[gi]),
        .full_o  (w_full[gi]),
        .empty_o (w_empty[gi]),
        .count_o (w_count[gi])
      );
    end
  endgenerate

  always_comb begin
    w_pause = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_pause = w_pause | (w_count[i] >= C_ALMOST_FULL);
    end
  end

  assign error_d = error_q | w_drop;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign bus.data_out0  = w_dout[0];
  assign bus.data_out1  = w_dout[1];
  assign bus.data_out2  = w_dout[2];
  assign bus.data_out3  = w_dout[3];
  assign bus.valid_out0 = w_valid[0];
  assign bus.valid_out1 = w_valid[1];
  assign bus.valid_out2 = w_valid[2];
  assign bus.valid_out3 = w_valid[3];
  assign bus.empty0     = w_empty[0];
  assign bus.empty1     = w_empty[1];
  assign bus.empty2     = w_empty[2];
  assign bus.empty3     = w_empty[3];
  assign bus.full0      = w_full[0];
  assign bus.full1      = w_full[1];
  assign bus.full2      = w_full[2];
  assign bus.full3      = w_full[3];
  assign bus.pause      = w_pause;
  assign bus.error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_1x4_fifo.sv
// ============================================================================
// tb_demux_1x4_fifo : directed scoreboard bench for demux_1x4_fifo
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux_1x4_fifo;

  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk;
  logic reset_L;

  demux_1x4_fifo_if #(.DATA_SIZE(DW)) bus ();

  demux_1x4_fifo #(
    .DATA_SIZE   (DW),
    .FIFO_DEPTH  (DEPTH),
    .ALMOST_FULL (AF)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: per-lane queue of words expected to come out, oldest first.
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] last_d [4];
  logic          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [3:0] exp_v);
    logic [DW-1:0] dout [4];
    logic [3:0]    vout, emp, ful;
    logic          any_af;
    dout = '{bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3};
    vout = {bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0};
    emp  = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
    ful  = {bus.full3, bus.full2, bus.full1, bus.full0};
    any_af = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid_out%0d", i), 32'(vout[i]), 32'(exp_v[i]));
      chk($sformatf("data_out%0d", i), 32'(dout[i]), 32'(last_d[i]));
      chk($sformatf("empty%0d", i), 32'(emp[i]), 32'(mq[i].size() == 0));
      chk($sformatf("full%0d", i), 32'(ful[i]), 32'(mq[i].size() == DEPTH));
      if (mq[i].size() >= AF) any_af = 1'b1;
    end
    chk("pause", 32'(bus.pause), 32'(any_af));
    chk("error", 32'(bus.error), 32'(exp_err));
  endtask

  // One clock: drive at negedge, update the model, sample 1 time unit after posedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [3:0] p);
    int            sz [4];
    logic [3:0]    exp_v;
    logic [1:0]    dst;
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    {bus.pop3, bus.pop2, bus.pop1, bus.pop0} = p;
    for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
    exp_v = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && sz[i] > 0) begin
        exp_v[i]  = 1'b1;
        last_d[i] = mq[i].pop_front();
      end
    end
    dst = d[DW-1 -: 2];
    if (v) begin
      if (sz[dst] == DEPTH) exp_err = 1'b1;
      else                  mq[dst].push_back(d);
    end
    @(posedge clk);
    #1;
    check_outputs(exp_v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      last_d[i] = '0;
    end
    exp_err = 1'b0;
  endtask

  initial begin
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.pop0 = 1'b0; bus.pop1 = 1'b0; bus.pop2 = 1'b0; bus.pop3 = 1'b0;
    model_reset();
    #2;
    check_outputs(4'b0);
    @(negedge clk);
    reset_L = 1'b1;

    // One word into each lane, then pop all lanes together.
    step(1'b1, 12'h123, 4'h0);
    step(1'b1, 12'h456, 4'h0);
    step(1'b1, 12'hAAA, 4'h0);
    step(1'b1, 12'hDDD, 4'h0);
    step(1'b0, 12'h000, 4'hF);
    step(1'b0, 12'h000, 4'h0);

    // Fill lane 2 through almost-full to full, drain it with pointer wrap.
    step(1'b1, 12'hAAA, 4'h0);
    step(1'b1, 12'hBBB, 4'h0);
    step(1'b1, 12'hAB0, 4'h0);
    step(1'b1, 12'hA01, 4'h0);
    step(1'b0, 12'h000, 4'h4);
    step(1'b1, 12'hA02, 4'h4);
    step(1'b0, 12'h000, 4'h4);
    step(1'b0, 12'h000, 4'h4);
    step(1'b0, 12'h000, 4'h4);
    step(1'b0, 12'h000, 4'h4);

    // Lane 3 full: a push with a simultaneous pop is dropped and error sticks.
    step(1'b1, 12'hC01, 4'h0);
    step(1'b1, 12'hC02, 4'h0);
    step(1'b1, 12'hC03, 4'h0);
    step(1'b1, 12'hC04, 4'h0);
    step(1'b1, 12'hCCC, 4'h8);
    step(1'b0, 12'h000, 4'h0);
    step(1'b0, 12'h000, 4'h8);
    step(1'b0, 12'h000, 4'h8);
    step(1'b0, 12'h000, 4'h8);
    step(1'b0, 12'h000, 4'h8);

    // Pop of an empty lane with a same-cycle push to it: no bypass.
    step(1'b1, 12'h456, 4'h2);
    step(1'b0, 12'h000, 4'h2);

    // Same-cycle push and pop on a non-empty lane keeps occupancy.
    step(1'b1, 12'h011, 4'h0);
    step(1'b1, 12'h022, 4'h1);
    step(1'b0, 12'h000, 4'h1);

    // Asynchronous reset between edges with lanes partly filled.
    step(1'b1, 12'h0F0, 4'h0);
    step(1'b1, 12'h4F1, 4'h0);
    step(1'b1, 12'h8F2, 4'h0);
    step(1'b1, 12'h8F3, 4'h0);
    step(1'b1, 12'h8F4, 4'h4);
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.pop0 = 1'b0; bus.pop1 = 1'b0; bus.pop2 = 1'b0; bus.pop3 = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_outputs(4'b0);
    @(negedge clk);
    reset_L = 1'b1;
    step(1'b0, 12'h000, 4'hF);
    step(1'b1, 12'h8F9, 4'h0);
    step(1'b0, 12'h000, 4'h4);

    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.pop0 = 1'b0; bus.pop1 = 1'b0; bus.pop2 = 1'b0; bus.pop3 = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
